// File: rtl/fifo_axis_tx_pkg.sv
// Shared constants for the FIFO-to-AXI-Stream packet transmitter.
package fifo_axis_tx_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } tx_state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_LEN_WIDTH  = 10;

endpackage

// File: rtl/fifo_axis_tx.sv
// Pops a fixed number of words from an upstream FIFO and presents them as one
// AXI-Stream packet, with a registered one-deep output stage.
module fifo_axis_tx
    import fifo_axis_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_re,
    input  logic                  fifo_rempty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tlast
);

    tx_state_t            state;
    tx_state_t            state_next;
    logic [LEN_WIDTH-1:0] remaining;
    logic                 accept;
    logic                 last_accept;
    logic                 start_ok;

    assign accept      = m_tvalid & m_tready;
    assign last_accept = accept & m_tlast;
    assign start_ok    = start & (len != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A pop is only allowed when the output register is empty or draining this cycle.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        fifo_re    = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                busy    = 1'b1;
                fifo_re = (remaining != '0) & ~fifo_rempty & (~m_tvalid | m_tready);
                if (last_accept) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
        end else if ((state == IDLE) && start_ok) begin
            remaining <= len;
        end else if (fifo_re) begin
            remaining <= remaining - LEN_WIDTH'(1);
        end
    end

    // The word popped while one beat remains is the last beat of the packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end else if (fifo_re) begin
            m_tdata  <= fifo_rdata;
            m_tvalid <= 1'b1;
            m_tlast  <= (remaining == LEN_WIDTH'(1));
        end else if (accept) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= last_accept;
        end
    end

endmodule

// File: tb/tb_fifo_axis_tx.sv
// Bench for fifo_axis_tx: queue-backed upstream FIFO, packet-level scoreboard,
// directed corner cases, a vector table and randomized traffic.
module tb_fifo_axis_tx;

    localparam int DW = 8;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          fifo_re;
    logic          fifo_rempty;
    logic [DW-1:0] fifo_rdata;
    logic          m_tvalid;
    logic          m_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;

    fifo_axis_tx #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .fifo_re     (fifo_re),
        .fifo_rempty (fifo_rempty),
        .fifo_rdata  (fifo_rdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tdata     (m_tdata),
        .m_tlast     (m_tlast)
    );

    always #5 clk = ~clk;

    // Upstream FIFO: written by the stimulus, popped by the DUT, cleared by rst_n.
    logic [DW-1:0] mem [0:255];
    int wr_ptr    = 0;
    int rd_ptr    = 0;
    int pop_count = 0;

    assign fifo_rempty = (wr_ptr == rd_ptr);
    assign fifo_rdata  = mem[rd_ptr[7:0]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 0;
        end else if (fifo_re) begin
            rd_ptr    <= rd_ptr + 1;
            pop_count <= pop_count + 1;
        end
    end

    // Reference model: a packet of length L carries the next L words written.
    logic [DW-1:0] model_words [$];
    bit            model_busy;
    bit            model_done;
    int            cur_len;
    int            beat_idx;
    int            model_pops;

    int checks_total  = 0;
    int checks_passed = 0;
    int hs_count      = 0;
    int ready_pct      = 100;
    int push_pct       = 0;
    int busy_start_pct = 0;

    bit            s_valid, s_last, s_hs, s_done, s_busy, s_re;
    logic [DW-1:0] s_data;
    bit            prev_stall, prev_last;
    logic [DW-1:0] prev_data;

    typedef struct {
        int len;
        int preload;
        int ready_pct;
        int exp_beats;
        int exp_left;
    } vec_t;

    vec_t vecs [5];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        mem[wr_ptr[7:0]] = w;
        wr_ptr++;
        model_words.push_back(w);
    endtask

    task automatic modelReset();
        model_words.delete();
        model_busy = 1'b0;
        model_done = 1'b0;
        cur_len    = 0;
        beat_idx   = 0;
        model_pops = 0;
        prev_stall = 1'b0;
    endtask

    task automatic sampleOutputs();
        bit            was_busy;
        logic [DW-1:0] exp_word;
        s_valid = m_tvalid;
        s_last  = m_tlast;
        s_data  = m_tdata;
        s_done  = done;
        s_busy  = busy;
        s_re    = fifo_re;
        s_hs    = m_tvalid && m_tready;
        if (!rst_n) begin
            modelReset();
            return;
        end
        checkOutput("busy", busy, model_busy);
        checkOutput("done", done, model_done);
        if (prev_stall) begin
            checkOutput("stall_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_last, prev_data});
        end
        if (fifo_re) begin
            model_pops++;
            checkOutput("pop_legal", {fifo_rempty, model_busy, model_pops <= cur_len}, 3'b011);
        end
        was_busy   = model_busy;
        model_done = 1'b0;
        if (s_hs) begin
            hs_count++;
            beat_idx++;
            if (model_words.size() == 0) begin
                checkOutput("beat_expected", 0, 1);
            end else begin
                exp_word = model_words.pop_front();
                checkOutput("beat_data", m_tdata, exp_word);
            end
            checkOutput("beat_last", m_tlast, beat_idx == cur_len);
            if (beat_idx == cur_len) begin
                model_done = 1'b1;
                model_busy = 1'b0;
            end
        end
        if (!was_busy && start && (len != '0)) begin
            model_busy = 1'b1;
            cur_len    = int'(len);
            beat_idx   = 0;
            model_pops = 0;
        end
        prev_stall = m_tvalid && !m_tready;
        prev_last  = m_tlast;
        prev_data  = m_tdata;
    endtask

    // Called at a falling edge: drive inputs, sample 1 time unit later, wait for next falling edge.
    task automatic applyStimulus(input logic st, input logic [LW-1:0] ln);
        start    = st;
        len      = ln;
        m_tready = (int'($urandom_range(0, 99)) < ready_pct);
        if (rst_n && push_pct > 0 && (wr_ptr - rd_ptr) < 16 && int'($urandom_range(0, 99)) < push_pct) begin
            push(DW'($urandom));
        end
        if (!st && model_busy && int'($urandom_range(0, 99)) < busy_start_pct) begin
            start = 1'b1;
            len   = LW'($urandom_range(0, 12));
        end
        #1;
        sampleOutputs();
        @(negedge clk);
    endtask

    task automatic resetDut();
        rst_n  = 1'b0;
        start  = 1'b0;
        len    = '0;
        wr_ptr = 0;
        modelReset();
        applyStimulus(1'b0, '0);
        applyStimulus(1'b0, '0);
        rst_n = 1'b1;
    endtask

    task automatic waitDone(input int max_cycles, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < max_cycles && !found; i++) begin
            applyStimulus(1'b0, '0);
            if (s_done) found = 1'b1;
        end
        checkOutput(name, found, 1);
    endtask

    initial begin
        logic [DW-1:0] got [4];
        int            cyc [4];
        int            n;
        int            done_at;
        int            base_pops;
        int            base_hs;
        bit            found;

        rst_n    = 1'b0;
        start    = 1'b0;
        len      = '0;
        m_tready = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_fifo_re", fifo_re, 0);
        checkOutput("rst_stream", {m_tvalid, m_tlast, m_tdata}, 0);
        rst_n = 1'b1;

        // Four-beat packet at full throughput.
        resetDut();
        ready_pct = 100;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        applyStimulus(1'b1, 10'd4);
        n = 0;
        done_at = -1;
        for (int i = 0; i < 4; i++) begin
            got[i] = '0;
            cyc[i] = 0;
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, '0);
            if (s_hs && n < 4) begin
                got[n] = s_data;
                cyc[n] = i;
                n++;
            end
            if (s_done) done_at = i;
        end
        checkOutput("p1_beats", n, 4);
        checkOutput("p1_first", got[0], 8'h11);
        checkOutput("p1_fourth", got[3], 8'h44);
        checkOutput("p1_consecutive", cyc[3] - cyc[0], 3);
        checkOutput("p1_done_delay", done_at, cyc[3] + 1);

        // Downstream backpressure holding the first beat.
        resetDut();
        ready_pct = 0;
        push(8'hA1); push(8'hA2); push(8'hA3);
        base_pops = pop_count;
        applyStimulus(1'b1, 10'd3);
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            applyStimulus(1'b0, '0);
            if (s_valid) found = 1'b1;
        end
        checkOutput("p2_valid_seen", found, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0);
            checkOutput("p2_hold_data", s_data, 8'hA1);
        end
        checkOutput("p2_single_pop", pop_count - base_pops, 1);
        ready_pct = 100;
        waitDone(20, "p2_done");
        checkOutput("p2_pops", pop_count - base_pops, 3);

        // Upstream underrun mid-packet.
        resetDut();
        ready_pct = 100;
        push(8'hB1); push(8'hB2);
        base_hs = hs_count;
        applyStimulus(1'b1, 10'd4);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            applyStimulus(1'b0, '0);
            if (hs_count - base_hs == 2) found = 1'b1;
        end
        checkOutput("p3_two_beats", found, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0);
            checkOutput("p3_gap_valid", s_valid, 0);
            checkOutput("p3_gap_busy", s_busy, 1);
        end
        push(8'hB3); push(8'hB4);
        waitDone(20, "p3_done");
        checkOutput("p3_beats", hs_count - base_hs, 4);

        // Short packet from a fuller FIFO, start while busy, zero-length start.
        resetDut();
        ready_pct = 100;
        for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
        base_pops = pop_count;
        applyStimulus(1'b1, 10'd2);
        applyStimulus(1'b1, 10'd5);
        waitDone(20, "p4_done");
        checkOutput("p4_pops", pop_count - base_pops, 2);
        checkOutput("p4_left", wr_ptr - rd_ptr, 4);
        applyStimulus(1'b1, 10'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0);
            checkOutput("p4_zero_len_idle", {s_busy, s_done}, 0);
        end
        checkOutput("p4_no_more_pops", pop_count - base_pops, 2);

        // Asynchronous reset mid-packet.
        resetDut();
        ready_pct = 100;
        for (int i = 0; i < 5; i++) push(8'hD0 + 8'(i));
        base_hs = hs_count;
        applyStimulus(1'b1, 10'd5);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(1'b0, '0);
            if (hs_count - base_hs == 2) found = 1'b1;
        end
        checkOutput("p5_two_beats", found, 1);
        rst_n  = 1'b0;
        wr_ptr = 0;
        #1;
        checkOutput("p5_rst_stream", {m_tvalid, m_tlast, m_tdata}, 0);
        checkOutput("p5_rst_status", {busy, done, fifo_re}, 0);
        modelReset();
        applyStimulus(1'b0, '0);
        applyStimulus(1'b0, '0);
        rst_n = 1'b1;
        push(8'hE0); push(8'hE1); push(8'hE2);
        base_pops = pop_count;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0);
            checkOutput("p5_no_pop", s_re, 0);
        end
        checkOutput("p5_pop_count", pop_count - base_pops, 0);

        // New start accepted in the done cycle.
        resetDut();
        ready_pct = 100;
        push(8'hF1); push(8'hF2); push(8'hF3);
        base_hs = hs_count;
        applyStimulus(1'b1, 10'd2);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (done) found = 1'b1;
            else applyStimulus(1'b0, '0);
        end
        checkOutput("p6_first_done", found, 1);
        applyStimulus(1'b1, 10'd1);
        applyStimulus(1'b0, '0);
        checkOutput("p6_rebusy", s_busy, 1);
        waitDone(10, "p6_second_done");
        checkOutput("p6_beats", hs_count - base_hs, 3);
        checkOutput("p6_left", wr_ptr - rd_ptr, 0);

        // Vector table: {len, preloaded words, ready %, expected beats, words left}.
        vecs[0] = '{1, 1, 100, 1, 0};
        vecs[1] = '{5, 8, 50, 5, 3};
        vecs[2] = '{3, 3, 30, 3, 0};
        vecs[3] = '{8, 10, 80, 8, 2};
        vecs[4] = '{2, 2, 100, 2, 0};
        for (int v = 0; v < 5; v++) begin
            resetDut();
            ready_pct = vecs[v].ready_pct;
            for (int k = 0; k < vecs[v].preload; k++) push(DW'($urandom));
            base_hs = hs_count;
            applyStimulus(1'b1, LW'(vecs[v].len));
            waitDone(200, "vec_done");
            checkOutput("vec_beats", hs_count - base_hs, vecs[v].exp_beats);
            checkOutput("vec_left", wr_ptr - rd_ptr, vecs[v].exp_left);
        end

        // Randomized traffic: random ready, sporadic FIFO writes, starts while busy.
        resetDut();
        ready_pct      = 70;
        push_pct       = 40;
        busy_start_pct = 25;
        for (int p = 0; p < 25; p++) begin
            applyStimulus(1'b1, LW'($urandom_range(1, 12)));
            waitDone(400, "rand_done");
        end
        push_pct       = 0;
        busy_start_pct = 0;
        checkOutput("rand_level", wr_ptr - rd_ptr, model_words.size());

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", checks_passed, checks_total);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
